// File: rtl/cache_config_pkg.sv
// Shared cache-hierarchy configuration: bus widths, L3 arbiter requester count
// and the arbiter state encoding used by l3_bus_arbiter and topmod.
package cache_config;

    localparam int CACHE_ADDRESS_WIDTH = 32;
    localparam int CACHE_DATA_WIDTH    = 32;

    // Number of L2 requesters sharing the L3 port; topmod sizes its wiring from this too.
    localparam int ARB_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESPOND
    } arb_state_t;

endpackage

// File: rtl/l3_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester set after last_grant,
// wrapping modulo NUM_REQ, returned one-hot.
module rr_priority_picker
    import cache_config::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] next_grant,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_grant = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx] && (next_grant == '0)) begin
                next_grant[idx] = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/l3_bus_arbiter.sv
// Round-robin arbiter sharing the single L3 port among the per-core L2 caches.
// Optional WAIT watchdog enabled by defining L3_ARB_TIMEOUT_EN.
module l3_bus_arbiter
    import cache_config::*;
#(
    parameter int NUM_REQ        = ARB_NUM_REQ,
    parameter int ADDRESS_WIDTH  = CACHE_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = CACHE_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          resp_error,
    output logic                          l3_read_request,
    output logic                          l3_write_request,
    output logic [ADDRESS_WIDTH-1:0]      l3_address,
    output logic [DATA_WIDTH-1:0]         l3_write_data,
    input  logic [DATA_WIDTH-1:0]         l3_read_data,
    input  logic                          l3_ready,
    output logic                          arb_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("l3_bus_arbiter: NUM_REQ and TIMEOUT_CYCLES must both be at least 2");
    end

    arb_state_t                state;
    logic [IDX_W-1:0]          last_grant;
    logic [IDX_W-1:0]          win_idx;
    logic [NUM_REQ-1:0]        next_grant;
    logic                      any_req;
    logic [ADDRESS_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]     win_wdata;
    logic                      win_write;
    logic                      lat_write;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .next_grant (next_grant),
        .any_req    (any_req)
    );

    // Steer the winning requester's slice onto the latch inputs.
    always_comb begin
        win_idx   = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (next_grant[i]) begin
                win_idx   = IDX_W'(i);
                win_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                win_write = req_write[i];
            end
        end
    end

`ifdef L3_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_count;
`else
    assign resp_error  = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked block, and all state uses <=.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ARB_IDLE;
            last_grant       <= IDX_W'(NUM_REQ - 1);
            grant            <= '0;
            resp_valid       <= '0;
            resp_rdata       <= '0;
            l3_read_request  <= 1'b0;
            l3_write_request <= 1'b0;
            l3_address       <= '0;
            l3_write_data    <= '0;
            lat_write        <= 1'b0;
`ifdef L3_ARB_TIMEOUT_EN
            resp_error       <= 1'b0;
            arb_timeout      <= 1'b0;
            wait_count       <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant            <= next_grant;
                        last_grant       <= win_idx;
                        lat_write        <= win_write;
                        l3_address       <= win_addr;
                        l3_write_data    <= win_wdata;
                        l3_read_request  <= ~win_write;
                        l3_write_request <= win_write;
                        state            <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    l3_read_request  <= 1'b0;
                    l3_write_request <= 1'b0;
`ifdef L3_ARB_TIMEOUT_EN
                    wait_count       <= '0;
`endif
                    state            <= ARB_WAIT;
                end

                ARB_WAIT: begin
                    if (l3_ready) begin
                        resp_valid <= grant;
                        resp_rdata <= lat_write ? '0 : l3_read_data;
                        state      <= ARB_RESPOND;
                    end
`ifdef L3_ARB_TIMEOUT_EN
                    else if (wait_count == WAIT_LIMIT) begin
                        resp_valid  <= grant;
                        resp_rdata  <= '0;
                        resp_error  <= 1'b1;
                        arb_timeout <= 1'b1;
                        state       <= ARB_RESPOND;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
`endif
                end

                ARB_RESPOND: begin
                    // Completion pulse ends; the port is released on entry to IDLE.
                    resp_valid  <= '0;
                    resp_rdata  <= '0;
                    grant       <= '0;
`ifdef L3_ARB_TIMEOUT_EN
                    resp_error  <= 1'b0;
                    arb_timeout <= 1'b0;
`endif
                    state       <= ARB_IDLE;
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l3_bus_arbiter.sv
// Self-checking bench for l3_bus_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level round-robin model.
module tb_l3_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    r_valid = '0;
    logic [N-1:0]    r_write = '0;
    logic [AW-1:0]   r_addr  [N];
    logic [DW-1:0]   r_wdata [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant, resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic            resp_error, arb_timeout;
    logic            l3_read_request, l3_write_request;
    logic [AW-1:0]   l3_address;
    logic [DW-1:0]   l3_write_data;
    logic [DW-1:0]   l3_read_data = '0;
    logic            l3_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    assign req_addr  = {r_addr[3], r_addr[2], r_addr[1], r_addr[0]};
    assign req_wdata = {r_wdata[3], r_wdata[2], r_wdata[1], r_wdata[0]};

    always #5 clk = ~clk;

    l3_bus_arbiter #(
        .NUM_REQ        (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (r_valid),
        .req_write        (r_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .grant            (grant),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .l3_read_request  (l3_read_request),
        .l3_write_request (l3_write_request),
        .l3_address       (l3_address),
        .l3_write_data    (l3_write_data),
        .l3_read_data     (l3_read_data),
        .l3_ready         (l3_ready),
        .arb_timeout      (arb_timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {grant, resp_valid, resp_error, arb_timeout,
                              l3_read_request, l3_write_request}, '0);
        check({tag, "_data"}, {l3_address, l3_write_data}, '0);
        check({tag, "_rdata"}, resp_rdata, '0);
    endtask

    task automatic reset_dut();
        reset    = 1'b1;
        r_valid  = '0;
        l3_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected round-robin winner straight from the arbitration rule.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Wait for the strobe of a granted transaction, answer it after `delay`
    // cycles, check the completion and release the requester.
    task automatic serve(input string tag, input logic [N-1:0] exp_grant, input bit wr,
                         input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                         input int delay, input logic [DW-1:0] l3_rd,
                         input logic [DW-1:0] exp_rdata);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(l3_read_request || l3_write_request) && n < 16);
        check({tag, "_latency"}, n, 1);
        check({tag, "_grant"}, grant, exp_grant);
        check({tag, "_strobe"}, {l3_read_request, l3_write_request}, wr ? 2'b01 : 2'b10);
        check({tag, "_addr"}, l3_address, exp_addr);
        if (wr) check({tag, "_wdata"}, l3_write_data, exp_wdata);
        for (int i = 0; i < N; i++) begin
            if (exp_grant[i]) begin
                r_addr[i]  = ~exp_addr;
                r_wdata[i] = ~exp_wdata;
            end
        end
        tick();
        check({tag, "_strobe_1cyc"}, {l3_read_request, l3_write_request}, 2'b00);
        repeat (delay - 1) tick();
        l3_ready     = 1'b1;
        l3_read_data = l3_rd;
        tick();
        l3_ready     = 1'b0;
        l3_read_data = 32'h5555_AAAA;
        check({tag, "_resp"}, resp_valid, exp_grant);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {resp_error, arb_timeout}, 2'b00);
        check({tag, "_addr_hold"}, l3_address, exp_addr);
        r_valid = r_valid & ~exp_grant;
        tick();
        check({tag, "_release"}, {grant, resp_valid}, '0);
    endtask

    typedef struct {
        int          req;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] l3_rdata;
        int          delay;
        logic [3:0]  exp_grant;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef enum {M_IDLE, M_BUSY, M_RESP} mphase_t;

    task automatic random_phase();
        mphase_t     ph = M_IDLE;
        int          last_srv = N - 1;
        int          win = 0, cnt = 0, served = 0;
        bit          sent = 1'b0, wrf = 1'b0;
        logic [31:0] la = '0, lw = '0, erd = '0;
        logic [1:0]  exp_s;
        logic [3:0]  exp_r, exp_g;
        reset_dut();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            exp_s = 2'b00;
            exp_r = '0;
            case (ph)
                M_IDLE: if (r_valid != '0) begin
                    win      = rr_pick(r_valid, last_srv);
                    last_srv = win;
                    wrf      = r_write[win];
                    la       = r_addr[win];
                    lw       = r_wdata[win];
                    exp_s    = wrf ? 2'b01 : 2'b10;
                    cnt      = $urandom_range(1, 4);
                    sent     = 1'b0;
                    ph       = M_BUSY;
                end
                M_BUSY: if (sent) begin
                    exp_r = 4'b0001 << win;
                    ph    = M_RESP;
                end
                default: ph = M_IDLE;
            endcase
            exp_g = (ph == M_IDLE) ? 4'b0000 : (4'b0001 << win);
            check("rnd_strobe", {l3_read_request, l3_write_request}, exp_s);
            check("rnd_grant", grant, exp_g);
            check("rnd_resp", resp_valid, exp_r);
            if (exp_s != 2'b00) begin
                check("rnd_addr", l3_address, la);
                if (wrf) check("rnd_wdata", l3_write_data, lw);
            end
            if (exp_r != '0) begin
                check("rnd_rdata", resp_rdata, wrf ? 32'h0 : erd);
                check("rnd_err", {resp_error, arb_timeout}, 2'b00);
            end
            if (ph == M_BUSY) check("rnd_addr_hold", l3_address, la);

            if (exp_r != '0) begin
                r_valid[win] = 1'b0;
                served++;
            end else if (ph == M_BUSY) begin
                r_addr[win]  = $urandom;
                r_wdata[win] = $urandom;
            end
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && !exp_r[i] && $urandom_range(0, 3) == 0) begin
                    r_valid[i] = 1'b1;
                    r_write[i] = 1'($urandom_range(0, 1));
                    r_addr[i]  = $urandom;
                    r_wdata[i] = $urandom;
                end
            end
            l3_read_data = $urandom;
            if (ph == M_BUSY && exp_s == 2'b00) begin
                if (cnt > 0) cnt--;
                l3_ready = 1'b0;
                if (cnt == 0 && !sent) begin
                    l3_ready = 1'b1;
                    sent     = 1'b1;
                    erd      = l3_read_data;
                end
            end else begin
                l3_ready = 1'($urandom_range(0, 1));
            end
        end
        check("rnd_served_enough", 64'(served >= 100), 64'd1);
    endtask

    initial begin
        vec_t vecs [5];
        bit   bad;

        for (int i = 0; i < N; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end

        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 4'b0001, 32'hDEAD_BEEF};
        vecs[1] = '{1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 1, 4'b0010, 32'h0};
        vecs[2] = '{3, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 2, 4'b1000, 32'h0000_0001};
        vecs[3] = '{2, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 4, 4'b0100, 32'h0};
        vecs[4] = '{2, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1, 4'b0100, 32'h0};

        // Reset values
        reset = 1'b1;
        tick();
        check_idle_outputs("reset");
        reset_dut();

        // Single-requester transactions from the table
        for (int v = 0; v < 5; v++) begin
            r_write[vecs[v].req] = vecs[v].wr;
            r_addr[vecs[v].req]  = vecs[v].addr;
            r_wdata[vecs[v].req] = vecs[v].wdata;
            r_valid[vecs[v].req] = 1'b1;
            serve($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].wr, vecs[v].addr,
                  vecs[v].wdata, vecs[v].delay, vecs[v].l3_rdata, vecs[v].exp_rdata);
        end

        // All four together out of reset: served 0,1,2,3
        reset_dut();
        for (int i = 0; i < N; i++) begin
            r_write[i] = 1'b0;
            r_addr[i]  = 32'h1000 + 32'(i * 16);
        end
        r_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            serve($sformatf("all4_%0d", i), 4'(1 << i), 1'b0, 32'h1000 + 32'(i * 16),
                  32'h0, 1, 32'h100 + 32'(i), 32'h100 + 32'(i));
        end

        // Requester 2 served, then 2 and 3 together: 3 goes first
        reset_dut();
        r_write = '0;
        r_addr[2] = 32'h2000;
        r_valid[2] = 1'b1;
        serve("rr2_first", 4'b0100, 1'b0, 32'h2000, 32'h0, 1, 32'h22, 32'h22);
        r_addr[2] = 32'h2100;
        r_addr[3] = 32'h3100;
        r_valid   = 4'b1100;
        serve("rr2_then3", 4'b1000, 1'b0, 32'h3100, 32'h0, 2, 32'h33, 32'h33);
        serve("rr2_then2", 4'b0100, 1'b0, 32'h2100, 32'h0, 2, 32'h44, 32'h44);

        // Reset in WAIT aborts silently; pointer returns to favour requester 0
        reset_dut();
        r_write   = '0;
        r_addr[0] = 32'h0000_0200;
        r_valid   = 4'b0001;
        tick();
        check("rstwait_strobe", l3_read_request, 1'b1);
        tick();
        reset        = 1'b1;
        l3_ready     = 1'b1;
        l3_read_data = 32'h9999_9999;
        tick();
        check_idle_outputs("rstwait");
        reset     = 1'b0;
        l3_ready  = 1'b0;
        r_addr[2] = 32'h0000_0300;
        r_valid   = 4'b0101;
        serve("rstwait_r0", 4'b0001, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h1, 32'h1);
        serve("rstwait_r2", 4'b0100, 1'b0, 32'h0000_0300, 32'h0, 1, 32'h2, 32'h2);

        // l3_ready held low: watchdog completion, or unbounded wait without it
        r_write[1]   = 1'b0;
        r_addr[1]    = 32'h0000_0400;
        r_valid      = 4'b0010;
        l3_read_data = 32'h7777_7777;
        tick();
        check("stall_strobe", l3_read_request, 1'b1);
        bad = 1'b0;
`ifdef L3_ARB_TIMEOUT_EN
        repeat (8) begin
            tick();
            if (resp_valid != '0 || arb_timeout) bad = 1'b1;
        end
        check("tmo_early", bad, 1'b0);
        tick();
        check("tmo_resp", resp_valid, 4'b0010);
        check("tmo_flags", {resp_error, arb_timeout}, 2'b11);
        check("tmo_rdata", resp_rdata, 32'h0);
        r_valid = '0;
        tick();
        check("tmo_release", {grant, resp_valid, resp_error, arb_timeout}, '0);
`else
        repeat (40) begin
            tick();
            if (resp_valid != '0 || arb_timeout || resp_error) bad = 1'b1;
        end
        check("nowdog_hold", bad, 1'b0);
        check("nowdog_grant", grant, 4'b0010);
        l3_ready = 1'b1;
        tick();
        l3_ready = 1'b0;
        check("nowdog_resp", resp_valid, 4'b0010);
        check("nowdog_rdata", resp_rdata, 32'h7777_7777);
        check("nowdog_err", {resp_error, arb_timeout}, 2'b00);
        r_valid = '0;
        tick();
        check("nowdog_release", {grant, resp_valid}, '0);
`endif

        random_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
